// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared encodings for the banked data memory: access sizes,
//             controller states and the byte-enable helper.
//  Revision : 1.0  initial release
// ============================================================================
package md_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Little-endian byte lanes touched by an access of the given size
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_ram.sv
`default_nettype none
// ============================================================================
//  Module   : md_ram
//  Purpose  : DEPTH x 32 storage array, single port, asynchronous read,
//             byte-lane write enables.
//  Revision : 1.0  initial release
// ============================================================================
module md_ram #(
    parameter int    DEPTH     = 512,
    parameter string INIT_FILE = "",
    parameter int    AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Merge the enabled byte lanes into the addressed word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/md_banked.sv
`default_nettype none
// ============================================================================
//  Module   : md_banked
//  Purpose  : Byte-addressed data memory for the IMIPS MEM stage. Handles
//             byte/half/word loads and stores with sign/zero extension,
//             programmable wait states and a valid/ready request handshake.
//             Misaligned, out-of-range and reserved-size requests complete
//             with resp_err and never touch the array.
//  Revision : 1.0  initial release
// ============================================================================
module md_banked
    import md_pkg::*;
#(
    parameter int    DEPTH       = 512,
    parameter int    ADDR_W      = 32,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = "single_port_rom.txt"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = ($clog2(WAIT_STATES + 1) > 1) ? $clog2(WAIT_STATES + 1) : 1;
    // Counter value on the final wait cycle (unreachable when there are no waits)
    localparam logic [c_cnt_w-1:0] c_last_wait = c_cnt_w'(WAIT_STATES - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_wdata;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_rdata;
    logic                 r_resp_err;

    logic [c_idx_w-1:0]   w_idx;
    logic [1:0]           w_lane;
    logic                 w_oor;
    logic                 w_misal;
    logic                 w_err;
    logic [3:0]           w_be;
    logic [3:0]           w_ram_be;
    logic [31:0]          w_ram_wdata;
    logic [31:0]          w_ram_rdata;
    logic [31:0]          w_shifted;
    logic [31:0]          w_load_ext;

    assign w_idx  = r_addr[c_idx_w+1:2];
    assign w_lane = r_addr[1:0];

    // Any set bit above the word index puts the access past the array
    if (ADDR_W > c_idx_w + 2) begin : g_range
        assign w_oor = |r_addr[ADDR_W-1:c_idx_w+2];
    end else begin : g_no_range
        assign w_oor = 1'b0;
    end

    assign w_misal = ((r_size == SZ_H) && w_lane[0]) ||
                     ((r_size == SZ_W) && (w_lane != 2'b00));
    assign w_err   = (r_size == SZ_RSV) || w_misal || w_oor;
    assign w_be    = byte_en(r_size, w_lane);

    // Replicate the right-justified store data onto every lane it may target
    always_comb begin
        w_ram_wdata = r_wdata;
        case (r_size)
            SZ_B:    w_ram_wdata = {4{r_wdata[7:0]}};
            SZ_H:    w_ram_wdata = {2{r_wdata[15:0]}};
            default: w_ram_wdata = r_wdata;
        endcase
    end

    // Stores commit only on the edge leaving ACCESS; a reset on that edge cancels it
    assign w_ram_be = ((r_state == ST_ACCESS) && r_we && !w_err && !rst) ? w_be : 4'b0000;

    md_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_idx),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_shifted = w_ram_rdata >> {w_lane, 3'b000};

    // Extend the addressed lane(s) of the loaded word
    always_comb begin
        w_load_ext = w_ram_rdata;
        case (r_size)
            SZ_B:    w_load_ext = r_uns ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_H:    w_load_ext = r_uns ? {16'h0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = w_ram_rdata;
        endcase
    end

    // Request sequencer: latch on accept, optional wait, access, one-cycle response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_size       <= SZ_B;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_uns       <= req_unsigned;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == c_last_wait) begin
                        r_cnt   <= '0;
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= w_err;
                    r_resp_rdata <= (!r_we && !w_err) ? w_load_ext : 32'h0;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_md_banked.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_banked
//  Purpose  : Self-checking bench for md_banked: directed vector table,
//             wait-state timing, reset abort and a randomised scoreboard run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_banked;

    localparam int DEPTH = 64;
    localparam int N_RAND = 5000;

    logic clk = 1'b0;
    logic rst;

    logic        v0, rdy0, we0, un0, rv0, er0;
    logic [1:0]  sz0;
    logic [31:0] ad0, wd0, rd0;

    logic        v3, rdy3, we3, un3, rv3, er3;
    logic [1:0]  sz3;
    logic [31:0] ad3, wd3, rd3;

    md_banked #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
        .req_size(sz0), .req_unsigned(un0), .req_addr(ad0), .req_wdata(wd0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0));

    md_banked #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
        .req_size(sz3), .req_unsigned(un3), .req_addr(ad3), .req_wdata(wd3),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // One request on the zero-wait instance; returns response, latency and pulse width flag
    task automatic req0(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic pulse_ok);
        int guard;
        lat = -1; rd = 'x; er = 1'bx; pulse_ok = 1'b0;
        @(negedge clk);
        we0 = we; sz0 = sz; un0 = uns; ad0 = addr; wd0 = wd; v0 = 1'b1;
        guard = 0;
        while (!rdy0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy0) begin
            v0 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        we0 = 1'($urandom); sz0 = 2'($urandom); un0 = 1'($urandom);
        ad0 = $urandom; wd0 = $urandom;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rv0) begin
                lat = k;
                break;
            end
        end
        rd = rd0;
        er = er0;
        @(negedge clk);
        pulse_ok = !rv0;
    endtask

    // Reference memory and access model
    logic [31:0] mem_m [DEPTH];

    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int idx, lane;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        er = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
             (sz == 2'b10 && addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
        rd = 32'h0;
        if (er) return;
        idx  = int'(addr[31:2]);
        lane = int'(addr[1:0]);
        word = mem_m[idx];
        if (we) begin
            case (sz)
                2'b00:   word[8*lane +: 8] = wd[7:0];
                2'b01:   word[16*(lane/2) +: 16] = wd[15:0];
                default: word = wd;
            endcase
            mem_m[idx] = word;
        end else begin
            b = word[8*lane +: 8];
            h = word[16*(lane/2) +: 16];
            case (sz)
                2'b00:   rd = uns ? {24'h0, b} : {{24{b[7]}}, b};
                2'b01:   rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
                default: rd = word;
            endcase
        end
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [21];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, pok, any_rv;
        int          lat;
        int          acc[$];
        int          rsp[$];
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wd;

        //               we    sz     uns   addr          wdata          rdata         err
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h11,  32'hAAAAAA7F, 32'h00000000, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD7FEF, 1'b0};
        tbl[5]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h0000DEAD, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 1'b0, 32'h0,   32'h0000A5C3, 32'h00000000, 1'b0};
        tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h2,   32'h0,        32'h00000000, 1'b1};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h1,   32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 32'h0,   32'h0,        32'h00000000, 1'b1};
        tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1};
        tbl[12] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'h11111111, 32'h00000000, 1'b1};
        tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'h0000A5C3, 1'b0};
        tbl[14] = '{1'b0, 2'b00, 1'b1, 32'h0,   32'h0,        32'h000000C3, 1'b0};
        tbl[15] = '{1'b0, 2'b00, 1'b0, 32'h0,   32'h0,        32'hFFFFFFC3, 1'b0};
        tbl[16] = '{1'b1, 2'b01, 1'b0, 32'h2,   32'h1234BEEF, 32'h00000000, 1'b0};
        tbl[17] = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'hBEEFA5C3, 1'b0};
        tbl[18] = '{1'b0, 2'b01, 1'b0, 32'h0,   32'h0,        32'hFFFFA5C3, 1'b0};
        tbl[19] = '{1'b1, 2'b00, 1'b1, 32'h3,   32'hFFFFFF01, 32'h00000000, 1'b0};
        tbl[20] = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'h01EFA5C3, 1'b0};

        rst = 1'b1;
        v0 = 1'b0; we0 = 1'b0; sz0 = 2'b00; un0 = 1'b0; ad0 = '0; wd0 = '0;
        v3 = 1'b0; we3 = 1'b0; sz3 = 2'b10; un3 = 1'b0; ad3 = '0; wd3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset req_ready", 32'(rdy0), 32'd1);
        check("reset resp_valid", 32'(rv0), 32'd0);
        check("reset resp_rdata", rd0, 32'h0);
        check("reset resp_err", 32'(er0), 32'd0);

        // Directed table: stores, loads, extension and error cases
        for (int i = 0; i < 21; i++) begin
            req0(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, rd, er, lat, pok);
            check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_er));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d pulse", i), 32'(pok), 32'd1);
        end

        // Three wait states, valid held high: accept every 6 cycles, response 5 after
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            v3 = 1'b1;
            if (rdy3) acc.push_back(n);
            if (rv3) begin
                rsp.push_back(n);
                check($sformatf("ws3 err %0d", rsp.size()), 32'(er3), 32'd0);
            end
        end
        v3 = 1'b0;
        check("ws3 accept count", 32'(acc.size()), 32'd4);
        check("ws3 resp count", 32'(rsp.size()), 32'd3);
        if (acc.size() >= 4 && rsp.size() >= 3) begin
            for (int j = 0; j < 3; j++) begin
                check($sformatf("ws3 spacing %0d", j), 32'(acc[j+1] - acc[j]), 32'd6);
                check($sformatf("ws3 latency %0d", j), 32'(rsp[j] - acc[j]), 32'd5);
            end
        end

        // Fill array with a known pattern, mirrored in the model
        for (int i = 0; i < DEPTH; i++) begin
            req0(1'b1, 2'b10, 1'b0, 32'(i * 4), 32'hC0DE0000 | 32'(i), rd, er, lat, pok);
            mem_m[i] = 32'hC0DE0000 | 32'(i);
            check($sformatf("fill%0d err", i), 32'(er), 32'd0);
        end

        // Reset one cycle after a store is accepted: store dropped, no response
        @(negedge clk);
        we0 = 1'b1; sz0 = 2'b10; un0 = 1'b0; ad0 = 32'h20; wd0 = 32'h12345678; v0 = 1'b1;
        check("abort ready before accept", 32'(rdy0), 32'd1);
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        any_rv = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rv0) any_rv = 1'b1;
        end
        check("abort no resp_valid", 32'(any_rv), 32'd0);
        check("abort req_ready", 32'(rdy0), 32'd1);
        check("abort resp_rdata", rd0, 32'h0);
        check("abort resp_err", 32'(er0), 32'd0);
        req0(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, pok);
        check("abort reread", rd, 32'hC0DE0008);

        // Random mix against the scoreboard model, with random idle gaps
        for (int i = 0; i < N_RAND; i++) begin
            int r;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r   = int'($urandom_range(0, 9));
            sz  = (r == 0) ? 2'b11 : 2'(r % 3);
            we  = 1'($urandom);
            uns = 1'($urandom);
            wd  = $urandom;
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'b01) addr[0] = 1'b0;
                if (sz == 2'b10) addr[1:0] = 2'b00;
            end
            model(we, sz, uns, addr, wd, exp_rd, exp_er);
            req0(we, sz, uns, addr, wd, rd, er, lat, pok);
            check($sformatf("rand%0d rdata", i), rd, exp_rd);
            check($sformatf("rand%0d err", i), 32'(er), 32'(exp_er));
            check($sformatf("rand%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("rand%0d pulse", i), 32'(pok), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
